// File: rtl/dmem_responder_if.sv
// LSQ <-> data-memory request/response bundle.
// The LSQ drives requests as master; dmem_responder answers as slave.
`timescale 1ns/1ps

interface dmem_responder_if;
    logic        valid_in;
    logic        rw_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  ldstID_in;
    logic        stall_out;
    logic [31:0] data_out;
    logic [3:0]  ldstID_out;
    logic        ready_out;

    modport master (
        output valid_in, rw_in, addr_in, data_in, ldstID_in,
        input  stall_out, data_out, ldstID_out, ready_out
    );

    modport slave (
        input  valid_in, rw_in, addr_in, data_in, ldstID_in,
        output stall_out, data_out, ldstID_out, ready_out
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: in-order request FIFO feeding a fixed-latency service
// FSM over a word array, with one-cycle tagged responses.
`timescale 1ns/1ps

module dmem_responder_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count_q,
    input logic             stall_q,
    input logic             push_s
);
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_stall_full: assert property (@(posedge clk) disable iff (rst)
        stall_q == (count_q == CNT_W'(DEPTH)));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        (count_q == CNT_W'(DEPTH)) |-> !push_s);
endmodule

module dmem_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3,
    parameter int WORDS   = 1024
) (
    input logic            clk,
    input logic            rst,
    dmem_responder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(LATENCY);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             rw;
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic [3:0]       tag;
    } req_t;

    req_t             fifo_q [DEPTH];
    logic [31:0]      mem_q  [WORDS];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    req_t             svc_q, svc_d;
    logic             stall_q, stall_d;
    logic             ready_q, ready_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       tag_q, tag_d;

    req_t             req_s;
    logic             push_s;
    logic             pop_s;
    logic             complete_s;
    logic             mem_we_s;
    logic [31-IDX_W:0] unused_addr_s;

    assign unused_addr_s  = {bus.addr_in[31:IDX_W+2], bus.addr_in[1:0]};
    assign bus.stall_out  = stall_q;
    assign bus.ready_out  = ready_q;
    assign bus.data_out   = data_q;
    assign bus.ldstID_out = tag_q;

    // Handshake decode: only entries already queued before the edge may pop.
    always_comb begin
        req_s      = {bus.rw_in, bus.addr_in[IDX_W+1:2], bus.data_in, bus.ldstID_in};
        push_s     = bus.valid_in & ~stall_q;
        complete_s = (state_q == S_BUSY) && (cnt_q == LAT_W'(1));
        pop_s      = (count_q != '0) && ((state_q == S_IDLE) || complete_s);
        mem_we_s   = complete_s & svc_q.rw;
    end

    // Next-state for FIFO bookkeeping, service FSM and response outputs.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        stall_d = (count_d == CNT_FULL);

        state_d = state_q;
        cnt_d   = cnt_q;
        svc_d   = svc_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    state_d = S_BUSY;
                    cnt_d   = LAT_RELOAD;
                    svc_d   = fifo_q[rd_ptr_q];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (complete_s) begin
                    if (pop_s) begin
                        state_d = S_BUSY;
                        cnt_d   = LAT_RELOAD;
                        svc_d   = fifo_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d = complete_s;
        if (complete_s) begin
            tag_d  = svc_q.tag;
            // The array is read before this edge's write, so loads see old contents.
            data_d = svc_q.rw ? 32'h0000_0000 : mem_q[svc_q.idx];
        end else begin
            tag_d  = tag_q;
            data_d = data_q;
        end
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            svc_q    <= '0;
            stall_q  <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= 32'h0000_0000;
            tag_q    <= 4'h0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            svc_q    <= svc_d;
            stall_q  <= stall_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= req_s;
        end
    end

    // Word array; deliberately not reset so completed stores survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[svc_q.idx] <= svc_q.data;
        end
    end

    dmem_responder_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .count_q (count_q),
        .stall_q (stall_q),
        .push_s  (push_s)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a schedule-based
// reference model (service start = max(accept+1, previous completion)).
`timescale 1ns/1ps

module tb_dmem_responder;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 3;
    localparam int WORDS   = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          rw;
        int          idx;
        logic [31:0] data;
        logic [3:0]  tag;
        int          start;
        int          comp;
    } rec_t;

    rec_t        pend[$];
    logic [31:0] ref_mem [WORDS];
    bit          written [WORDS];
    int          cyc;
    int          last_comp;
    int          n_cmp;
    int          n_fail;
    logic        exp_ready, exp_stall;
    logic [3:0]  exp_tag;
    logic [31:0] exp_data;
    logic [37:0] got, exp;
    bit          last_acc;

    task automatic reset_model();
        pend.delete();
        exp_ready = 1'b0;
        exp_stall = 1'b0;
        exp_tag   = 4'h0;
        exp_data  = 32'h0;
        last_comp = -100;
    endtask

    // Drive one request slot, advance one edge, update the model, sample DUT.
    task automatic tick(input bit v, input bit rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] tag);
        rec_t r;
        int   n;
        bus.valid_in  = v;
        bus.rw_in     = rw;
        bus.addr_in   = addr;
        bus.data_in   = data;
        bus.ldstID_in = tag;
        @(posedge clk);
        cyc++;
        last_acc  = v && !exp_stall;
        exp_ready = 1'b0;
        if (pend.size() != 0 && pend[0].comp == cyc) begin
            r = pend.pop_front();
            exp_ready = 1'b1;
            exp_tag   = r.tag;
            if (r.rw) begin
                ref_mem[r.idx] = r.data;
                exp_data = 32'h0;
            end else begin
                exp_data = ref_mem[r.idx];
            end
        end
        if (last_acc) begin
            r.rw    = rw;
            r.idx   = int'(addr[11:2]);
            r.data  = data;
            r.tag   = tag;
            r.start = (cyc + 1 > last_comp) ? cyc + 1 : last_comp;
            r.comp  = r.start + LATENCY - 1;
            last_comp = r.comp;
            pend.push_back(r);
        end
        n = 0;
        foreach (pend[i]) if (pend[i].start > cyc) n++;
        exp_stall = (n == DEPTH);
        #1;
        got = {bus.ready_out, bus.stall_out, bus.ldstID_out, bus.data_out};
        exp = {exp_ready, exp_stall, exp_tag, exp_data};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_in = 1'b0; bus.rw_in = 1'b0; bus.addr_in = 32'h0;
        bus.data_in = 32'h0; bus.ldstID_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        got = {bus.ready_out, bus.stall_out, bus.ldstID_out, bus.data_out};
        n_cmp++;
        if (got !== 38'h0) begin
            n_fail++; $display("FAIL reset got=%h exp=%h", got, 38'h0);
        end
        rst = 1'b0;
        reset_model();
        cyc = -1;
    endtask

    task automatic test_single_write();
        int seen;
        seen = -1;
        tick(1'b1, 1'b1, 32'd40, 32'd9000, 4'd1);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL single_write cyc=%0d got=%h exp=%h", cyc, got, exp); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (bus.ready_out === 1'b1) seen = cyc;
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL single_write cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        n_cmp++;
        if (seen !== 3) begin n_fail++; $display("FAIL single_write_latency edge got=%0d exp=3", seen); end
    endtask

    task automatic test_raw();
        tick(1'b1, 1'b1, 32'd44, 32'd9001, 4'd2);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL raw cyc=%0d got=%h exp=%h", cyc, got, exp); end
        tick(1'b1, 1'b0, 32'd44, 32'h0, 4'd3);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL raw cyc=%0d got=%h exp=%h", cyc, got, exp); end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL raw cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 32'd256 + 32'(4 * k), 32'h1000 + 32'(k), 4'(4 + k));
            if (last_acc) k++;
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        for (int i = 0; i < 30 && pend.size() != 0; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        n_cmp++;
        if (pend.size() != 0) begin n_fail++; $display("FAIL back_to_back_drain pending=%0d exp=0", pend.size()); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b1, 32'd40, 32'hDEAD, 4'd9);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, got, exp); end
        tick(1'b1, 1'b0, 32'd44, 32'h0, 4'd10);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, got, exp); end
        tick(1'b1, 1'b0, 32'd40, 32'h0, 4'd11);
        n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, got, exp); end
        bus.valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        got = {bus.ready_out, bus.stall_out, bus.ldstID_out, bus.data_out};
        n_cmp++;
        if (got !== 38'h0) begin n_fail++; $display("FAIL reset_mid_async got=%h exp=%h", got, 38'h0); end
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_mid_quiet cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        tick(1'b1, 1'b0, 32'd40, 32'h0, 4'd12);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_mid_read cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        n_cmp++;
        if (bus.data_out !== 32'd9000) begin n_fail++; $display("FAIL reset_mid_survive data=%0d exp=9000", bus.data_out); end
    endtask

    task automatic test_alias();
        tick(1'b1, 1'b1, 32'd40, 32'h0000_ABCD, 4'd5);
        tick(1'b1, 1'b0, 32'd4136, 32'h0, 4'd6);
        tick(1'b1, 1'b0, 32'd43, 32'h0, 4'd7);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL alias cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        n_cmp++;
        if (bus.data_out !== 32'h0000_ABCD || bus.ldstID_out !== 4'd7) begin
            n_fail++; $display("FAIL alias_final data=%h id=%0d exp data=0000abcd id=7", bus.data_out, bus.ldstID_out);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    task automatic test_random();
        bit          v, rw;
        int          idx;
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rw  = $urandom_range(0, 1) == 1;
            idx = $urandom_range(0, 15);
            if (!written[idx]) rw = 1'b1;
            addr = {12'($urandom), 10'(idx), 2'($urandom)} ;
            tick(v, rw, addr, $urandom, 4'($urandom));
            if (last_acc && rw) written[idx] = 1'b1;
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
        for (int i = 0; i < 30 && pend.size() != 0; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        foreach (written[i]) written[i] = 1'b0;
        test_reset();
        test_single_write();
        test_raw();
        test_back_to_back();
        test_reset_mid();
        test_alias();
        test_idle_hold();
        test_random();
        test_idle_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
